// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
// Buffers 12-bit RGB pixel words in a small FIFO and, on frame_start,
// serialises one 64-cycle slot per pixel (16-bit header, three
// zero-separated 12-bit colour fields, 9 trailing zeros), followed by a
// low latch gap and a one-cycle frame_done pulse. Drives the rec_data
// input of the first digital_control unit in the LED chain.

module led_frame_scheduler #(
  parameter int unsigned NUM_PIX    = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 128,
  parameter logic [15:0] HEADER     = 16'h7FFF
) (
  input  logic        balanced_clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [11:0] pix_r,
  input  logic [11:0] pix_g,
  input  logic [11:0] pix_b,
  input  logic        frame_start,
  output logic        ser_out,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned WORD_W = 55;
  localparam int unsigned PIX_W  = 36;

  localparam logic [5:0]       LAST_DATA_BIT = 6'd54;
  localparam logic [5:0]       LAST_SLOT_BIT = 6'd63;
  localparam logic [7:0]       LAST_PIX      = 8'(NUM_PIX - 1);
  localparam logic [GAP_W-1:0] LAST_GAP      = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PIX,
    SEND,
    GAP
  } state_t;

  // ---------------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------------
  logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [PIX_W-1:0] head_pix;

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_t            state;
  logic [WORD_W-1:0] shifter;
  logic [WORD_W-1:0] slot_word;
  logic [5:0]        bit_cnt;
  logic [7:0]        pix_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              slot_end;
  logic              last_pix;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  // Ready is forced low while reset is asserted so no word slips in.
  assign pix_ready  = rst_n && !fifo_full;
  assign push       = pix_valid && pix_ready;
  assign head_pix   = fifo_mem[rd_ptr];

  // Slot word is built straight from the FIFO head so a pop and the
  // shifter load happen on the same edge.
  assign slot_word = {HEADER, 1'b0, head_pix[35:24],
                      1'b0, head_pix[23:12],
                      1'b0, head_pix[11:0]};

  assign slot_end = (bit_cnt == LAST_SLOT_BIT);
  assign last_pix = (pix_cnt == LAST_PIX);

  // Pop decision: every state that loads the shifter takes the FIFO head.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pop = 1'b0;
    case (state)
      IDLE:     pop = frame_start && !fifo_empty;
      WAIT_PIX: pop = !fifo_empty;
      SEND:     pop = slot_end && !last_pix && !fifo_empty;
      default:  pop = 1'b0;
    endcase
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leave the
  // count unchanged.
  always_ff @(posedge balanced_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge balanced_clk) begin
    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, so stale contents are never read out.
    if (push) fifo_mem[wr_ptr] <= {pix_r, pix_g, pix_b};
  end

  // Frame sequencer: slot serialisation, pixel/gap counting and all
  // registered outputs.
  always_ff @(posedge balanced_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shifter    <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      gap_cnt    <= '0;
      ser_out    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      busy       <= (state != IDLE);
      frame_done <= 1'b0;
      ser_out    <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            pix_cnt <= '0;
            bit_cnt <= '0;
            if (!fifo_empty) begin
              shifter <= slot_word;
              state   <= SEND;
            end else begin
              state   <= WAIT_PIX;
            end
          end
        end

        WAIT_PIX: begin
          if (!fifo_empty) begin
            shifter <= slot_word;
            bit_cnt <= '0;
            state   <= SEND;
          end
        end

        SEND: begin
          ser_out <= (bit_cnt <= LAST_DATA_BIT) ? shifter[WORD_W-1] : 1'b0;
          shifter <= shifter << 1;
          bit_cnt <= bit_cnt + 6'd1;
          if (slot_end) begin
            if (last_pix) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              pix_cnt <= pix_cnt + 8'd1;
              if (!fifo_empty) begin
                // Back-to-back slot: reload overrides the shift, bit_cnt
                // wraps 63 -> 0 on its own.
                shifter <= slot_word;
              end else begin
                underrun <= 1'b1;
                state    <= WAIT_PIX;
              end
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == LAST_GAP) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed testbench for led_frame_scheduler (NUM_PIX=4, FIFO_DEPTH=4,
// GAP_CYCLES=128). Outputs are sampled 1 time unit after each rising edge;
// after tick() returns, the outputs show what that edge registered.

module tb_led_frame_scheduler;

  localparam int NPIX = 4;
  localparam int GAP  = 128;

  logic        balanced_clk = 1'b0;
  logic        rst_n        = 1'b0;
  logic        pix_valid    = 1'b0;
  logic [11:0] pix_r        = '0;
  logic [11:0] pix_g        = '0;
  logic [11:0] pix_b        = '0;
  logic        frame_start  = 1'b0;
  logic        pix_ready;
  logic        ser_out;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int n_cmp      = 0;
  int n_err      = 0;
  int busy_total = 0;

  logic [11:0] pr [11];
  logic [11:0] pg [11];
  logic [11:0] pb [11];

  led_frame_scheduler #(
    .NUM_PIX    (NPIX),
    .FIFO_DEPTH (4),
    .GAP_CYCLES (GAP),
    .HEADER     (16'h7FFF)
  ) dut (
    .balanced_clk (balanced_clk),
    .rst_n        (rst_n),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_r        (pix_r),
    .pix_g        (pix_g),
    .pix_b        (pix_b),
    .frame_start  (frame_start),
    .ser_out      (ser_out),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  always #5 balanced_clk = ~balanced_clk;

  task automatic tick();
    @(posedge balanced_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected 64 slot bits, slot position 0 in bit 63.
  function automatic logic [63:0] exp_slot(input logic [11:0] r, input logic [11:0] g,
                                           input logic [11:0] b);
    return {16'h7FFF, 1'b0, r, 1'b0, g, 1'b0, b, 9'b0};
  endfunction

  task automatic set_pix(input int idx);
    pix_r = pr[idx];
    pix_g = pg[idx];
    pix_b = pb[idx];
  endtask

  task automatic push_word(input int idx);
    set_pix(idx);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  // Record 64 consecutive ser_out samples; optionally pulse frame_start
  // in the cycle with index fs_at.
  task automatic capture_slot(output logic [63:0] bits, input int fs_at);
    bits = '0;
    for (int n = 0; n < 64; n++) begin
      frame_start = (n == fs_at);
      bits = {bits[62:0], ser_out};
      if (busy) busy_total++;
      tick();
    end
    frame_start = 1'b0;
  endtask

  // Behavioural digital_control receiver: check framing, decode the fields.
  task automatic decode_slot(input string pfx, input logic [63:0] bits, input int idx);
    check({pfx, "_hdr"}, bits[63:48], 16'h7FFF);
    check({pfx, "_sep"}, {bits[47], bits[34], bits[21]}, 3'b000);
    check({pfx, "_r"},   bits[46:35], pr[idx]);
    check({pfx, "_g"},   bits[33:22], pg[idx]);
    check({pfx, "_b"},   bits[20:9],  pb[idx]);
    check({pfx, "_tail"}, bits[8:0],  9'h000);
  endtask

  // Run through the latch gap, which starts on the current sample.
  task automatic run_gap(input string pfx, input int fs_at);
    int ones    = 0;
    int dones   = 0;
    int done_at = 0;
    int bcnt    = 0;
    for (int i = 0; i < GAP; i++) begin
      frame_start = (i == fs_at);
      if (ser_out) ones++;
      if (frame_done) begin
        dones++;
        done_at = i;
      end
      if (busy) begin
        bcnt++;
        busy_total++;
      end
      tick();
    end
    frame_start = 1'b0;
    check({pfx, "_gap_zeros"}, ones, 0);
    check({pfx, "_done_pulses"}, dones, 1);
    check({pfx, "_done_pos"}, done_at, GAP - 1);
    check({pfx, "_gap_busy"}, bcnt, GAP);
    check({pfx, "_busy_after"}, busy, 1'b0);
    check({pfx, "_done_after"}, frame_done, 1'b0);
  endtask

  initial begin
    logic [63:0] s;
    int ones;

    pr[0] = 12'hABC; pg[0] = 12'h123; pb[0] = 12'h5A5;
    pr[1] = 12'h001; pg[1] = 12'h800; pb[1] = 12'hFFF;
    pr[2] = 12'hF0F; pg[2] = 12'h0F0; pb[2] = 12'h555;
    pr[3] = 12'h3C3; pg[3] = 12'hAAA; pb[3] = 12'h000;
    pr[4] = 12'h123; pg[4] = 12'h456; pb[4] = 12'h789;
    pr[5] = 12'hFED; pg[5] = 12'hCBA; pb[5] = 12'h987;
    pr[6] = 12'h800; pg[6] = 12'h001; pb[6] = 12'h7FE;
    pr[7] = 12'h0AA; pg[7] = 12'hF55; pb[7] = 12'h1E1;
    pr[8] = 12'h111; pg[8] = 12'h222; pb[8] = 12'h333;
    pr[9] = 12'h444; pg[9] = 12'h555; pb[9] = 12'h666;
    pr[10] = 12'hC0D; pg[10] = 12'hE0F; pb[10] = 12'h0F0;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_pix_ready", pix_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", pix_ready, 1'b1);
    check("idle_busy", busy, 1'b0);

    // ---------------- fill FIFO, fifth word held ----------------
    for (int i = 0; i < 4; i++) begin
      push_word(i);
      check("fill_ready", pix_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    set_pix(4);
    pix_valid = 1'b1;
    repeat (2) tick();
    check("full_hold_ready", pix_ready, 1'b0);

    // ---------------- 4-pixel frame, no stall ----------------
    frame_start = 1'b1;
    tick();                          // edge k
    frame_start = 1'b0;
    check("ready_after_pop", pix_ready, 1'b1);
    check("busy_at_k", busy, 1'b0);
    tick();                          // edge k+1: fifth word accepted
    pix_valid = 1'b0;
    check("fifth_accepted", pix_ready, 1'b0);
    check("busy_k1", busy, 1'b1);
    check("ser_k1_hdr0", ser_out, 1'b0);
    busy_total = 0;
    capture_slot(s, -1);
    check("slot0_exact", s, exp_slot(pr[0], pg[0], pb[0]));
    check("slot0_first_one", s[62], 1'b1);
    decode_slot("f1s0", s, 0);
    capture_slot(s, 10);             // frame_start during SEND is ignored
    decode_slot("f1s1", s, 1);
    capture_slot(s, -1);
    decode_slot("f1s2", s, 2);
    capture_slot(s, -1);
    decode_slot("f1s3", s, 3);
    run_gap("f1", 20);               // frame_start during GAP is ignored
    check("f1_busy_total", busy_total, 64 * NPIX + GAP);
    check("f1_underrun", underrun, 1'b0);
    repeat (3) tick();
    check("f1_no_queued_start", busy, 1'b0);

    // ---------------- underrun: 2 pixels for a 4-pixel frame ----------------
    push_word(5);                    // FIFO now holds words 4 and 5
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    capture_slot(s, -1);
    check("f2s0_exact", s, exp_slot(pr[4], pg[4], pb[4]));
    capture_slot(s, -1);
    check("f2s1_exact", s, exp_slot(pr[5], pg[5], pb[5]));
    check("f2_underrun_set", underrun, 1'b1);
    check("f2_wait_busy", busy, 1'b1);
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      if (ser_out) ones++;
      tick();
    end
    check("f2_wait_low", ones, 0);
    set_pix(6);
    pix_valid = 1'b1;
    tick();                          // edge j: push into empty FIFO
    set_pix(7);                      // pushed at j+1 alongside the pop
    check("f2_ser_j", ser_out, 1'b0);
    tick();                          // edge j+1
    pix_valid = 1'b0;
    check("f2_ser_j1", ser_out, 1'b0);
    tick();                          // edge j+2: slot bit 0
    capture_slot(s, -1);
    check("f2s2_exact", s, exp_slot(pr[6], pg[6], pb[6]));
    capture_slot(s, -1);
    check("f2s3_exact", s, exp_slot(pr[7], pg[7], pb[7]));
    run_gap("f2", -1);
    check("f2_underrun_sticky", underrun, 1'b1);

    // ---------------- reset mid-frame ----------------
    push_word(8);
    push_word(9);
    push_word(10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    capture_slot(s, -1);
    check("f3s0_exact", s, exp_slot(pr[8], pg[8], pb[8]));
    repeat (30) tick();              // slot 2 bit 30 on the line
    rst_n = 1'b0;
    tick();
    check("mid_rst_ser", ser_out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    check("mid_rst_underrun", underrun, 1'b0);
    check("mid_rst_ready", pix_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", pix_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    push_word(0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    capture_slot(s, -1);
    check("f4s0_exact", s, exp_slot(pr[0], pg[0], pb[0]));
    check("f4_underrun", underrun, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Sequencer that drives the serial input of a daisy chain of LED digital-control units. It buffers 12-bit RGB pixel words from an upstream requester in a small FIFO. On command it emits one 64-cycle slot per pixel, each slot carrying header 16'h7FFF followed by the 39-bit RGB payload, for NUM_PIX pixels. It then holds the line low for a latch gap. It sits between the pixel source (pattern engine or host bridge) and the first `digital_control` unit's `rec_data` input, on the same `balanced_clk` domain.

## Interface
Parameters:
- NUM_PIX, 8: pixel slots per frame (1..255)
- FIFO_DEPTH, 4: pixel FIFO entries (power of 2, ≥2)
- GAP_CYCLES, 128: low cycles after last slot before frame_done (≥1)
- HEADER, 16'h7FFF: slot header value

Ports:
- balanced_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pix_valid  in  1  pixel word offered
- pix_ready  out  1  FIFO can accept a word
- pix_r  in  12  red
- pix_g  in  12  green
- pix_b  in  12  blue
- frame_start  in  1  single-cycle request to transmit one frame
- ser_out  out  1  serial stream to chain `rec_data`, registered
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of latch gap
- underrun  out  1  sticky: FIFO was empty at a slot boundary mid-frame

## Operation
- Single clock domain (balanced_clk). Reset is synchronous and active-low (rst_n).
- FIFO push: on pix_valid && pix_ready. pix_ready = !full; held 0 while rst_n low. A pop and a push in the same cycle are both legal, and the occupancy count is unchanged.
- Slot word, 55 bits MSB first: {HEADER[15:0], 1'b0, r[11:0], 1'b0, g[11:0], 1'b0, b[11:0]}. Slot bit positions 0..54 carry this word; positions 55..63 are driven 0.
- FSM states: IDLE, WAIT_PIX, SEND, GAP.
  - IDLE: ser_out=0. On frame_start=1:
    - FIFO non-empty → pop, load shifter, pix_cnt=0, bit_cnt=0, go SEND.
    - FIFO empty → go WAIT_PIX.
  - WAIT_PIX: ser_out=0. When FIFO becomes non-empty → pop, load shifter, bit_cnt=0, go SEND. pix_cnt is unchanged.
  - SEND: ser_out = shifter MSB for bit_cnt 0..54, else 0. bit_cnt increments each cycle. At bit_cnt==63:
    - pix_cnt==NUM_PIX-1 → gap_cnt=0, go GAP.
    - otherwise pix_cnt+1, then:
      - FIFO non-empty → pop, reload, bit_cnt=0, stay SEND (back-to-back slots, no idle cycle).
      - FIFO empty → set underrun, go WAIT_PIX.
  - GAP: ser_out=0. gap_cnt increments each cycle. At gap_cnt==GAP_CYCLES-1 → pulse frame_done, go IDLE.
- frame_start is ignored outside IDLE; requests are not queued.
- underrun is cleared only by reset.
- Counter widths: bit_cnt 6 bits, wraps naturally 63→0. pix_cnt is 8 bits. gap_cnt is wide enough for GAP_CYCLES-1.
- Reset mid-frame: the next edge with rst_n=0 forces:
  - state IDLE, ser_out 0, busy 0, frame_done 0, underrun 0
  - FIFO emptied, all counters 0
  - No partial slot resumes after reset.

## Timing
- Reset values: ser_out=0, busy=0, frame_done=0, underrun=0, pix_ready=0 during reset, then 1 after release (FIFO empty).
- frame_start sampled high at edge k with a non-empty FIFO: busy=1 and ser_out = HEADER[15] (0) at k+1.
  - Slot bit n is driven during cycle k+1+n.
  - First header '1' appears at k+2.
  - Payload bit 0 (separator) appears at k+17.
- Back-to-back slot s starts exactly 64 cycles after slot s-1.
- Full frame with no stall: busy high for 64·NUM_PIX + GAP_CYCLES cycles. frame_done is high in the last of those cycles. busy=0 in the cycle after.
- pix_ready drops the cycle after the push that fills the FIFO. It rises the cycle after a pop from full.
- WAIT_PIX exit: a push at edge j (FIFO empty) makes the FIFO non-empty after j. The pop and load happen at edge j+1, and slot bit 0 is driven at j+2.

## Test plan
- Reset then single pixel, NUM_PIX=1, r=12'hABC g=12'h123 b=12'h5A5, frame_start → ser_out over 64 cycles = 0,1×15, 0,ABC bits, 0,123 bits, 0,5A5 bits, 0×9. Then 128 zeros, frame_done one pulse, busy low after.
- FIFO preloaded with 4 pixels, NUM_PIX=4 → 4 contiguous slots with no idle between them. Each slot decodes to its pixel through a behavioural `digital_control` model. underrun stays 0.
- NUM_PIX=4, only 2 pixels preloaded → underrun=1 after slot 2 and ser_out stays 0 in WAIT_PIX. Push pixel 3 at edge j → its slot starts at j+2. The frame completes normally.
- Push 5 words with FIFO_DEPTH=4 and no frame running → pix_ready=0 after the 4th; the 5th is held by the source. Start a frame → pix_ready=1 the cycle after the first pop, and the 5th word is accepted.
- frame_start pulsed during SEND and GAP → ignored: slot count and frame_done timing are unchanged.
- rst_n low for 1 cycle at slot 2 bit 30 → next cycle: ser_out=0, busy=0, FIFO empty, underrun=0. A new frame_start with freshly pushed data transmits from header bit 0.
